// File: rtl/spike_rate_decoder_if.sv
// Result channel of the spike rate decoder: per-window count, last ISI,
// valid/ready handshake and the sticky overwrite flag.
interface spike_rate_decoder_if #(
    parameter int CNT_W = 8
);
    logic [CNT_W-1:0] rate_out;
    logic [CNT_W-1:0] isi_out;
    logic             out_valid;
    logic             out_ready;
    logic             overflow;

    modport master (
        output rate_out,
        output isi_out,
        output out_valid,
        output overflow,
        input  out_ready
    );

    modport slave (
        input  rate_out,
        input  isi_out,
        input  out_valid,
        input  overflow,
        output out_ready
    );
endinterface

// File: rtl/spike_rate_decoder.sv
// Decodes a LIF neuron spike train into a spike count per programmable window
// plus the most recent inter-spike interval, delivered over valid/ready.
module spike_rate_decoder #(
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic               spike_in,
    input  logic [CNT_W-1:0]   window_len,
    input  logic               clear,
    spike_rate_decoder_if.master out_if
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] ISI_CAP = CNT_MAX - 1'b1;

    // Window state
    logic             spike_d_q, spike_d_d;
    logic [CNT_W:0]   win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0] spike_cnt_q, spike_cnt_d;
    logic [CNT_W-1:0] isi_cnt_q, isi_cnt_d;
    logic [CNT_W-1:0] last_isi_q, last_isi_d;
    logic             first_seen_q, first_seen_d;

    // Result registers
    logic [CNT_W-1:0] rate_q, rate_d;
    logic [CNT_W-1:0] isi_out_q, isi_out_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;

    logic             evt;
    logic             win_end;
    logic             xfer;
    logic [CNT_W:0]   wlen;
    logic [CNT_W-1:0] cnt_sum;

    always_comb begin
        evt = ena & spike_in & ~spike_d_q;

        // A zero window length selects the full 2^CNT_W range.
        wlen = {1'b0, window_len};
        if (window_len == '0) begin
            wlen = {1'b1, {CNT_W{1'b0}}};
        end
        // >= so that shrinking window_len mid-window closes it promptly.
        win_end = ena & (win_cnt_q >= (wlen - 1'b1));
        xfer    = valid_q & out_if.out_ready;

        spike_d_d    = ena ? spike_in : spike_d_q;
        win_cnt_d    = win_cnt_q;
        spike_cnt_d  = spike_cnt_q;
        isi_cnt_d    = isi_cnt_q;
        last_isi_d   = last_isi_q;
        first_seen_d = first_seen_q;

        cnt_sum = spike_cnt_q;
        if (evt && (spike_cnt_q != CNT_MAX)) begin
            cnt_sum = spike_cnt_q + 1'b1;
        end

        // isi_cnt tops out at CNT_MAX-1 so the +1 here saturates at CNT_MAX.
        if (evt && first_seen_q) begin
            last_isi_d = isi_cnt_q + 1'b1;
        end
        if (evt) begin
            first_seen_d = 1'b1;
        end

        if (ena) begin
            win_cnt_d   = win_end ? '0 : (win_cnt_q + 1'b1);
            spike_cnt_d = win_end ? '0 : cnt_sum;
            if (evt) begin
                isi_cnt_d = '0;
            end else if (isi_cnt_q < ISI_CAP) begin
                isi_cnt_d = isi_cnt_q + 1'b1;
            end else begin
                isi_cnt_d = ISI_CAP;
            end
        end

        rate_d    = rate_q;
        isi_out_d = isi_out_q;
        valid_d   = valid_q;
        ovf_d     = ovf_q;
        if (win_end) begin
            rate_d    = cnt_sum;
            isi_out_d = last_isi_d;
            valid_d   = 1'b1;
            if (valid_q && !out_if.out_ready) begin
                ovf_d = 1'b1;
            end
        end else if (xfer) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spike_d_q    <= 1'b0;
            win_cnt_q    <= '0;
            spike_cnt_q  <= '0;
            isi_cnt_q    <= '0;
            last_isi_q   <= '0;
            first_seen_q <= 1'b0;
            rate_q       <= '0;
            isi_out_q    <= '0;
            valid_q      <= 1'b0;
            ovf_q        <= 1'b0;
        end else if (clear) begin
            spike_d_q    <= 1'b0;
            win_cnt_q    <= '0;
            spike_cnt_q  <= '0;
            isi_cnt_q    <= '0;
            last_isi_q   <= '0;
            first_seen_q <= 1'b0;
            rate_q       <= '0;
            isi_out_q    <= '0;
            valid_q      <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            spike_d_q    <= spike_d_d;
            win_cnt_q    <= win_cnt_d;
            spike_cnt_q  <= spike_cnt_d;
            isi_cnt_q    <= isi_cnt_d;
            last_isi_q   <= last_isi_d;
            first_seen_q <= first_seen_d;
            rate_q       <= rate_d;
            isi_out_q    <= isi_out_d;
            valid_q      <= valid_d;
            ovf_q        <= ovf_d;
        end
    end

    assign out_if.rate_out  = rate_q;
    assign out_if.isi_out   = isi_out_q;
    assign out_if.out_valid = valid_q;
    assign out_if.overflow  = ovf_q;
endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
- Receiver end of the neuron spike interface: consumes the 1-bit `spike` output of a LIF neuron tile.
- Decodes the spike train into a spike count per programmable observation window and the most recent inter-spike interval (ISI).
- Delivers results over a valid/ready handshake to downstream readout or coupling logic.

Parameters:
- CNT_W, 8, width of the spike counter, rate_out, ISI counter and isi_out. Widths below assume 8.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- ena  input  1  clock enable; all counting and spike sampling are frozen when low
- spike_in  input  1  spike from neuron; each rising edge is one event
- window_len  input  8  observation window length in ena-cycles; 0 means 256
- clear  input  1  synchronous clear of all state
- rate_out  output  8  spike count of the last completed window
- isi_out  output  8  last ISI in ena-cycles at window close
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result
- overflow  output  1  sticky flag: an unread result was overwritten

Behaviour:
- One clock: clk. Reset is asynchronous and active-high on rst.
- Reset: rate_out=0, isi_out=0, out_valid=0, overflow=0. Internals also reset: spike_d=0, win_cnt=0, spike_cnt=0, isi_cnt=0, last_isi=0, first_seen=0.
- Priority: rst > clear > normal operation.
  - clear gives the reset state on the next edge, regardless of ena or out_ready.
- Event detection:
  - event = ena & spike_in & ~spike_d.
  - spike_d <= spike_in only when ena=1.
  - A level held high for N cycles counts as 1 event.
  - A high spike_in at the first ena cycle after reset counts as an event.
- Window counter:
  - wlen = (window_len==0) ? 256 : window_len, 9-bit.
  - win_end = ena & (win_cnt >= wlen-1). The >= comparison makes a mid-window decrease of window_len close the window at the next ena cycle.
  - On ena: win_cnt <= win_end ? 0 : win_cnt+1.
- Spike counter:
  - On ena: spike_cnt <= win_end ? 0 : sat255(spike_cnt + event).
  - The count latched at win_end includes an event occurring in that same cycle.
- ISI:
  - On ena without event: isi_cnt <= min(isi_cnt+1, 254).
  - On event: isi_cnt <= 0; first_seen <= 1.
  - If first_seen was already 1: last_isi <= isi_cnt+1. Max 255, which means 255 or more.
  - Events at ena-cycles t1 and t2 give ISI = t2-t1.
  - last_isi is not cleared at window end; it persists across windows.
- Result latch at win_end:
  - rate_out <= final count.
  - isi_out <= last_isi, including an update in the same cycle.
  - out_valid <= 1.
- Handshake:
  - A transfer happens at a posedge with out_valid & out_ready, independent of ena.
  - Transfer without win_end: out_valid <= 0.
  - Transfer with win_end: new data loaded, out_valid stays 1, overflow unchanged.
  - win_end while out_valid=1 and out_ready=0: data overwritten, out_valid stays 1, overflow <= 1.
  - overflow is sticky until clear or rst.
  - Outputs are stable while out_valid=1 and no win_end occurs.
- ena=0: win_cnt, spike_cnt, isi_cnt and spike_d hold. The handshake still completes.
- Latency: out_valid rises on the edge that ends the window, i.e. after wlen ena-cycles from reset, clear or the previous window end.

Test Plan:
1. Periodic operation: window_len=100, out_ready=1, spike_in 1-cycle pulse every 10 cycles starting cycle 5 -> out_valid pulses after cycle 100, rate_out=10, isi_out=10.
2. Held level and no ISI: window_len=20, spike_in held high cycles 3-7, otherwise low -> rate_out=1, isi_out=0 (single event).
3. Overflow and clear: out_ready=0, window_len=8, two full windows with 2 then 3 events -> rate_out=3, overflow=1, out_valid=1. Then clear=1 for 1 cycle -> all outputs 0.
4. ISI saturation and default window: window_len=0, one spike at cycle 0, next at cycle 300 -> isi_out=255. First window closes at cycle 256 with rate_out=1.
5. Enable gating: ena toggled 1/0 every cycle, window_len=10 -> window closes after 20 clk cycles. A spike pulse present only while ena=0 is not counted.
6. Async reset: rst asserted mid-window without a clock edge -> outputs 0 immediately. After release, window restarts from win_cnt=0.
